// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the round-robin / explicit-select mux.
//   MODE_SEL / MODE_RR : encodings of the 1-bit mode input
//   ostate_t           : output register occupancy (EMPTY / FULL)
//   sel_w()            : width of a channel index, never less than 1
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: grant generation for rr_mux_n.
//   clk, reset : clock, synchronous active-high reset (clears ptr)
//   mode       : MODE_SEL = explicit sel, MODE_RR = round-robin from ptr
//   sel        : explicit channel index (ignored in MODE_RR)
//   in_valid   : per-channel request
//   take       : output register can accept a word this cycle
//   grant      : one-hot (or zero) grant, independent of take
//   gnt_idx    : index of the granted channel (0 when no grant)
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SELW     = sel_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mode,
    input  logic [SELW-1:0]     sel,
    input  logic [CHANNELS-1:0] in_valid,
    input  logic                take,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     gnt_idx
);

    logic [SELW-1:0] ptr;
    logic            found;
    int              idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (mode == MODE_SEL) begin
            // Out-of-range sel simply matches no channel.
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(sel) == i && in_valid[i]) begin
                    grant[i] = 1'b1;
                    gnt_idx  = SELW'(i);
                end
            end
        end else begin
            // Search ptr, ptr+1, ... wrapping at CHANNELS (not 2^SELW).
            for (int k = 0; k < CHANNELS; k++) begin
                idx = int'(ptr) + k;
                if (idx >= CHANNELS) idx = idx - CHANNELS;
                if (!found && in_valid[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    gnt_idx    = SELW'(idx);
                end
            end
        end
    end

    // ptr only moves on a round-robin transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (mode == MODE_RR && take && |grant) begin
            if (int'(gnt_idx) == CHANNELS - 1) ptr <= '0;
            else                               ptr <= gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel mux into a one-entry registered output with
// valid/ready handshakes on both sides.
//   clk, reset : clock, synchronous active-high reset
//   in_data    : CHANNELS*WIDTH flattened input data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready, at most one bit set
//   mode, sel  : grant mode (explicit sel / round-robin) and explicit select
//   out_data   : registered data of the selected channel
//   out_chan   : channel index of out_data
//   out_valid  : output register holds an undelivered word
//   out_ready  : downstream accepts the word
module rr_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    localparam int SELW    = sel_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    ostate_t             state, state_n;
    logic                load_en, take, xfer;
    logic [CHANNELS-1:0] grant;
    logic [SELW-1:0]     gnt_idx;
    logic [WIDTH-1:0]    gnt_data;

    assign out_valid = (state == FULL);
    assign load_en   = !out_valid || out_ready;
    // Reset blocks acceptance so nothing is lost in the cycle being cleared.
    assign take      = load_en && !reset;
    assign in_ready  = grant & {CHANNELS{take}};
    assign xfer      = |(in_valid & in_ready);

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .sel      (sel),
        .in_valid (in_valid),
        .take     (take),
        .grant    (grant),
        .gnt_idx  (gnt_idx)
    );

    // grant is one-hot, so an AND-OR select is sufficient.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) gnt_data = gnt_data | in_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   if (xfer) state_n = FULL;
            FULL:    if (xfer) state_n = FULL;
                     else if (out_ready) state_n = EMPTY;
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_n;
    end

    // Data and channel hold whenever nothing new is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_chan <= '0;
        end else if (xfer) begin
            out_data <= gnt_data;
            out_chan <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
module tb_rr_mux_n;
    import mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // CHANNELS=4 instance
    logic        reset;
    logic [63:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        out_valid, out_ready;

    // CHANNELS=3 instance
    logic        reset3;
    logic [47:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [15:0] out_data3;
    logic [1:0]  out_chan3;
    logic        out_valid3, out_ready3;

    rr_mux_n #(.WIDTH(16), .CHANNELS(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    rr_mux_n #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
        .clk(clk), .reset(reset3), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_chan(out_chan3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] d4 [4];
    logic [15:0] d3 [3];

    initial begin
        d4[0] = 16'hA000; d4[1] = 16'hA111; d4[2] = 16'hBEEF; d4[3] = 16'hA333;
        d3[0] = 16'hC000; d3[1] = 16'hC111; d3[2] = 16'hC222;
        in_data  = {d4[3], d4[2], d4[1], d4[0]};
        in_data3 = {d3[2], d3[1], d3[0]};

        reset = 1'b1; in_valid = 4'b1111; mode = MODE_RR; sel = 2'd0; out_ready = 1'b1;
        reset3 = 1'b1; in_valid3 = 3'b000; mode3 = MODE_SEL; sel3 = 2'd0; out_ready3 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  16'h0000);
        chk("rst_out_chan",  out_chan,  2'd0);

        // Explicit select of channel 2
        reset = 1'b0; mode = MODE_SEL; sel = 2'd2; in_valid = 4'b0100;
        #1 chk("sel2_in_ready", in_ready, 4'b0100);
        @(negedge clk);
        chk("sel2_out_data",  out_data,  16'hBEEF);
        chk("sel2_out_chan",  out_chan,  2'd2);
        chk("sel2_out_valid", out_valid, 1'b1);

        // Drain with no grant: valid drops, data held
        in_valid = 4'b0000;
        @(negedge clk);
        chk("drain_out_valid", out_valid, 1'b0);
        chk("drain_out_data",  out_data,  16'hBEEF);

        // Round robin, all valid: 0,1,2,3,0 back to back
        mode = MODE_RR; in_valid = 4'b1111;
        #1 chk("rr_first_ready", in_ready, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_chan", k),  out_chan,  k % 4);
            chk($sformatf("rr%0d_data", k),  out_data,  d4[k % 4]);
            chk($sformatf("rr%0d_valid", k), out_valid, 1'b1);
            chk($sformatf("rr%0d_ready", k), in_ready,  4'b0001 << ((k + 1) % 4));
        end

        // Backpressure: holds ch0 word for 5 cycles
        out_ready = 1'b0;
        #1 chk("bp_ready0", in_ready, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_data", k),  out_data,  16'hA000);
            chk($sformatf("bp%0d_valid", k), out_valid, 1'b1);
            chk($sformatf("bp%0d_ready", k), in_ready,  4'b0000);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 4'b0010);
        @(negedge clk);
        chk("bp_next_chan",  out_chan,  2'd1);
        chk("bp_next_data",  out_data,  16'hA111);
        chk("bp_next_valid", out_valid, 1'b1);

        // Explicit select of an invalid channel: no grant, output empties
        mode = MODE_SEL; sel = 2'd1; in_valid = 4'b1101;
        #1 chk("nogrant_ready", in_ready, 4'b0000);
        @(negedge clk);
        chk("nogrant_valid0", out_valid, 1'b0);
        @(negedge clk);
        chk("nogrant_valid1", out_valid, 1'b0);
        chk("nogrant_ready1", in_ready, 4'b0000);

        // CHANNELS=3: sel out of range
        reset3 = 1'b0; mode3 = MODE_SEL; sel3 = 2'd3; in_valid3 = 3'b111;
        #1 chk("c3_sel3_ready", in_ready3, 3'b000);
        @(negedge clk);
        chk("c3_sel3_valid", out_valid3, 1'b0);

        // CHANNELS=3 round robin wraps at 3
        mode3 = MODE_RR;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("c3rr%0d_chan", k),  out_chan3,  k % 3);
            chk($sformatf("c3rr%0d_data", k),  out_data3,  d3[k % 3]);
            chk($sformatf("c3rr%0d_valid", k), out_valid3, 1'b1);
        end

        // Reset while full: word discarded, nothing accepted, ptr back to 0
        reset3 = 1'b1;
        #1 chk("c3_rst_ready", in_ready3, 3'b000);
        @(negedge clk);
        chk("c3_rst_valid", out_valid3, 1'b0);
        chk("c3_rst_chan",  out_chan3,  2'd0);
        chk("c3_rst_data",  out_data3,  16'h0000);
        reset3 = 1'b0;
        #1 chk("c3_post_ready", in_ready3, 3'b001);
        @(negedge clk);
        chk("c3_post_chan",  out_chan3,  2'd0);
        chk("c3_post_valid", out_valid3, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
